// File: rtl/regfile_mp.sv
// Multi-port register file: parametrised width, depth and read-port count,
// with synchronous clear, optional zero register, write bypass and registered reads.
module regfile_mp #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    clr,
  input  logic                    we,
  input  logic [AW-1:0]           rd_i,
  input  logic [WIDTH-1:0]        dat_i,
  input  logic [NUM_RD*AW-1:0]    rs_i,
  output logic [NUM_RD*WIDTH-1:0] rs_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok;

  // A write is only real if it lands on an existing, writable register.
  assign wr_ok = we && ({1'b0, rd_i} < DEPTH_W) && !(ZERO_REG != 0 && rd_i == '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || (ZERO_REG != 0 && i == 0)) begin
        mem_q[i] <= '0;
      end else if (cen) begin
        if (clr) begin
          mem_q[i] <= '0;
        end else if (wr_ok && rd_i == AW'(i)) begin
          mem_q[i] <= dat_i;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] val_d;

    assign addr = rs_i[gi*AW +: AW];

    always_comb begin
      val_d = '0;
      if (({1'b0, addr} < DEPTH_W) && !(ZERO_REG != 0 && addr == '0)) begin
        if (BYPASS != 0 && cen && !clr && wr_ok && rd_i == addr) begin
          val_d = dat_i;
        end else if (BYPASS != 0 && cen && clr) begin
          val_d = '0;
        end else begin
          val_d = mem_q[addr];
        end
      end
    end

    if (READ_LAT != 0) begin : g_lat
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else if (cen) begin
          out_q <= val_d;
        end
      end

      assign rs_o[gi*WIDTH +: WIDTH] = out_q;
    end else begin : g_comb
      assign rs_o[gi*WIDTH +: WIDTH] = val_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: five configurations share one stimulus bus,
// expectations go through a cycle-stamped scoreboard queue.
module tb_regfile_mp;

  localparam int D_DEF = 0;
  localparam int D_NB  = 1;
  localparam int D_ZR  = 2;
  localparam int D_RL  = 3;
  localparam int D_NP  = 4;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        clr;
  logic        we;
  logic [2:0]  rd;
  logic [7:0]  dat8;
  logic [15:0] dat16;
  logic [5:0]  rs6;
  logic [8:0]  rs9;
  logic [15:0] o_def;
  logic [15:0] o_nb;
  logic [15:0] o_zr;
  logic [15:0] o_rl;
  logic [47:0] o_np;

  regfile_mp u_def (.clk(clk), .rst(rst), .cen(cen), .clr(clr), .we(we),
                    .rd_i(rd), .dat_i(dat8), .rs_i(rs6), .rs_o(o_def));
  regfile_mp #(.BYPASS(0)) u_nb (.clk(clk), .rst(rst), .cen(cen), .clr(clr), .we(we),
                    .rd_i(rd), .dat_i(dat8), .rs_i(rs6), .rs_o(o_nb));
  regfile_mp #(.ZERO_REG(1)) u_zr (.clk(clk), .rst(rst), .cen(cen), .clr(clr), .we(we),
                    .rd_i(rd), .dat_i(dat8), .rs_i(rs6), .rs_o(o_zr));
  regfile_mp #(.READ_LAT(1)) u_rl (.clk(clk), .rst(rst), .cen(cen), .clr(clr), .we(we),
                    .rd_i(rd), .dat_i(dat8), .rs_i(rs6), .rs_o(o_rl));
  regfile_mp #(.WIDTH(16), .DEPTH(6), .NUM_RD(3)) u_np (.clk(clk), .rst(rst), .cen(cen),
                    .clr(clr), .we(we), .rd_i(rd), .dat_i(dat16), .rs_i(rs9), .rs_o(o_np));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [15:0] exp;
    int          due;
  } sb_t;

  typedef struct {
    logic       c_en, c_clr, c_we;
    logic [2:0] a_rd;
    logic [7:0] d;
    logic [2:0] a0, a1;
    logic [7:0] e0, e1;
  } vec_t;

  sb_t  sbq[$];
  vec_t tbl[19];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;

  function automatic logic [15:0] outp(input int dut, input int port);
    case (dut)
      D_DEF:   return {8'h00, o_def[port*8 +: 8]};
      D_NB:    return {8'h00, o_nb[port*8 +: 8]};
      D_ZR:    return {8'h00, o_zr[port*8 +: 8]};
      D_RL:    return {8'h00, o_rl[port*8 +: 8]};
      D_NP:    return o_np[port*16 +: 16];
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic push(input string tag, input int dut, input int port,
                      input logic [15:0] e, input int lat);
    sb_t s;
    s.tag  = tag;
    s.dut  = dut;
    s.port = port;
    s.exp  = e;
    s.due  = cyc_no + lat;
    sbq.push_back(s);
  endtask

  task automatic check_due();
    sb_t         s;
    logic [15:0] got;
    int          n;
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      s = sbq.pop_front();
      if (s.due == cyc_no) begin
        got = outp(s.dut, s.port);
        total++;
        if (got !== s.exp) begin
          bad++;
          $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", s.tag, s.dut, s.port, got, s.exp);
        end else begin
          $display("ok   %s dut=%0d port=%0d val=%h", s.tag, s.dut, s.port, got);
        end
      end else begin
        sbq.push_back(s);
      end
    end
  endtask

  task automatic drive(input logic c_en, input logic c_clr, input logic c_we,
                       input logic [2:0] a_rd, input logic [15:0] d,
                       input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    @(negedge clk);
    rst   = 1'b0;
    cen   = c_en;
    clr   = c_clr;
    we    = c_we;
    rd    = a_rd;
    dat8  = d[7:0];
    dat16 = d;
    rs6   = {a1, a0};
    rs9   = {a2, a1, a0};
    cyc_no++;
  endtask

  task automatic settle();
    #2;
    check_due();
  endtask

  // Reset cycle deliberately carries a write to r3 that must be lost.
  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    cen   = 1'b1;
    clr   = 1'b0;
    we    = 1'b1;
    rd    = 3'd3;
    dat8  = 8'hEE;
    dat16 = 16'hEEEE;
    cyc_no++;
    settle();
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; clr = 1'b0; we = 1'b0;
    rd = '0; dat8 = '0; dat16 = '0; rs6 = '0; rs9 = '0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd5, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 8'hA5, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 8'hA5, 8'h3C};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA5, 8'h3C};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'd5, 8'h99, 3'd5, 3'd5, 8'h99, 8'h99};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0, 8'h99, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd5, 8'h44, 3'd5, 3'd5, 8'h99, 8'h99};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 8'h99, 8'hA5};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 3'd1, 3'd2, 8'h11, 8'h00};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 3'd2, 8'h22, 3'd1, 3'd2, 8'h11, 8'h22};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 3'd1, 8'hFF, 3'd1, 3'd2, 8'h00, 8'h00};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'h00, 8'h00};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 3'd4, 8'h4D, 3'd4, 3'd6, 8'h4D, 8'h00};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 8'h4D, 8'h4D};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd0, 8'h4D, 8'h00};

    // Default configuration, table-driven.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].c_en, tbl[i].c_clr, tbl[i].c_we, tbl[i].a_rd, {8'h00, tbl[i].d},
            tbl[i].a0, tbl[i].a1, 3'd0);
      push($sformatf("tbl%0d_p0", i), D_DEF, 0, {8'h00, tbl[i].e0}, 0);
      push($sformatf("tbl%0d_p1", i), D_DEF, 1, {8'h00, tbl[i].e1}, 0);
      settle();
    end

    // No bypass: the write cycle shows the old contents.
    do_reset();
    drive(1, 0, 1, 3'd5, 16'h0099, 3'd5, 3'd5, 3'd0);
    push("nb_wr_p0", D_NB, 0, 16'h0000, 0);
    push("nb_wr_p1", D_NB, 1, 16'h0000, 0);
    push("def_byp", D_DEF, 0, 16'h0099, 0);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 3'd0);
    push("nb_after", D_NB, 0, 16'h0099, 0);
    settle();
    drive(1, 0, 1, 3'd5, 16'h00AA, 3'd5, 3'd0, 3'd0);
    push("nb_old", D_NB, 0, 16'h0099, 0);
    settle();
    drive(1, 1, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 3'd0);
    push("nb_clr_old", D_NB, 0, 16'h00AA, 0);
    push("def_clr_byp", D_DEF, 0, 16'h0000, 0);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 3'd0);
    push("nb_cleared", D_NB, 0, 16'h0000, 0);
    settle();

    // Hardwired zero register.
    do_reset();
    drive(1, 0, 1, 3'd0, 16'h0055, 3'd0, 3'd0, 3'd0);
    push("zr_wr0_p0", D_ZR, 0, 16'h0000, 0);
    push("zr_wr0_p1", D_ZR, 1, 16'h0000, 0);
    push("def_wr0", D_DEF, 0, 16'h0055, 0);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd0, 3'd4, 3'd0);
    push("zr_r0", D_ZR, 0, 16'h0000, 0);
    push("zr_r4_empty", D_ZR, 1, 16'h0000, 0);
    push("def_r0", D_DEF, 0, 16'h0055, 0);
    settle();
    drive(1, 0, 1, 3'd4, 16'h00C4, 3'd4, 3'd0, 3'd0);
    push("zr_r4_byp", D_ZR, 0, 16'h00C4, 0);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd4, 3'd4, 3'd0);
    push("zr_r4_p0", D_ZR, 0, 16'h00C4, 0);
    push("zr_r4_p1", D_ZR, 1, 16'h00C4, 0);
    settle();

    // Registered read path.
    do_reset();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0);
    push("rl_rst_p0", D_RL, 0, 16'h0000, 0);
    push("rl_rst_p1", D_RL, 1, 16'h0000, 0);
    settle();
    drive(1, 0, 1, 3'd6, 16'h006E, 3'd0, 3'd0, 3'd0);
    push("rl_wr_p1", D_RL, 1, 16'h0000, 1);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd0, 3'd6, 3'd0);
    push("rl_lat_p1", D_RL, 1, 16'h006E, 1);
    settle();
    drive(0, 0, 0, 3'd0, 16'h0000, 3'd0, 3'd2, 3'd0);
    push("rl_hold_p1", D_RL, 1, 16'h006E, 1);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd6, 3'd6, 3'd0);
    push("rl_both_p0", D_RL, 0, 16'h006E, 1);
    push("rl_both_p1", D_RL, 1, 16'h006E, 1);
    settle();
    do_reset();
    drive(0, 0, 0, 3'd0, 16'h0000, 3'd6, 3'd6, 3'd0);
    push("rl_clr_p0", D_RL, 0, 16'h0000, 0);
    push("rl_clr_p1", D_RL, 1, 16'h0000, 0);
    push("rl_clr_hold", D_RL, 0, 16'h0000, 1);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd6, 3'd6, 3'd0);
    push("rl_mem_gone", D_RL, 0, 16'h0000, 1);
    settle();

    // Non-power-of-2 depth, 16-bit data, three read ports.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 3'(i), 16'hA000 + 16'(i) * 16'h0101, 3'd0, 3'd0, 3'd0);
      settle();
    end
    drive(1, 0, 1, 3'd7, 16'h7777, 3'd0, 3'd1, 3'd2);
    push("np_r0", D_NP, 0, 16'hA000, 0);
    push("np_r1", D_NP, 1, 16'hA101, 0);
    push("np_r2", D_NP, 2, 16'hA202, 0);
    settle();
    drive(1, 0, 1, 3'd6, 16'h6666, 3'd3, 3'd4, 3'd5);
    push("np_r3", D_NP, 0, 16'hA303, 0);
    push("np_r4", D_NP, 1, 16'hA404, 0);
    push("np_r5", D_NP, 2, 16'hA505, 0);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd6, 3'd7, 3'd5);
    push("np_oob6", D_NP, 0, 16'h0000, 0);
    push("np_oob7", D_NP, 1, 16'h0000, 0);
    push("np_r5_again", D_NP, 2, 16'hA505, 0);
    settle();
    drive(1, 0, 0, 3'd0, 16'h0000, 3'd5, 3'd0, 3'd3);
    push("np_r5b", D_NP, 0, 16'hA505, 0);
    push("np_r0b", D_NP, 1, 16'hA000, 0);
    push("np_r3b", D_NP, 2, 16'hA303, 0);
    settle();
    drive(1, 0, 1, 3'd2, 16'hBEEF, 3'd2, 3'd2, 3'd1);
    push("np_byp_p0", D_NP, 0, 16'hBEEF, 0);
    push("np_byp_p1", D_NP, 1, 16'hBEEF, 0);
    push("np_r1b", D_NP, 2, 16'hA101, 0);
    settle();

    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0);
      settle();
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d required=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the Gumnut 8x8 two-read/one-write register file.
- Generalised in data width, register count and number of read ports.
- Adds a synchronous clear, an optional hardwired-zero register 0, optional write-to-read bypass, and an optional registered read path.
- Sits between the decode stage (addresses) and the ALU/writeback stage (operands, result) of the core.
- The clock enable is a synchronous qualifier; the clock itself is never gated.

Parameters:
- WIDTH, 8: data width of each register.
- DEPTH, 8: number of registers, >= 2. Localparam AW = $clog2(DEPTH).
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 0: when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a same-cycle write to an address being read is forwarded to that read.
- READ_LAT, 0: 0 = combinational read; 1 = read data registered, one cycle latency.

Ports:
- clk  in  1: core clock, rising edge.
- rst  in  1: reset, synchronous, active-high.
- cen  in  1: clock enable; all state updates require cen=1.
- clr  in  1: synchronous clear of all registers.
- we  in  1: write enable.
- rd_i  in  AW: write address.
- dat_i  in  WIDTH: write data.
- rs_i  in  NUM_RD*AW: read addresses; port k occupies bits [k*AW +: AW].
- rs_o  out  NUM_RD*WIDTH: read data; port k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Reset:
  - When rst=1 at a rising edge, every register and every registered output (READ_LAT=1) becomes 0, regardless of cen, clr or we.
  - rst has the highest priority.
- Edge priority when rst=0: cen=0 -> no state change. Otherwise clr -> all registers 0 and we ignored. Otherwise we -> mem[rd_i] <= dat_i.
- Discarded writes:
  - a write to address 0 when ZERO_REG=1;
  - a write with rd_i >= DEPTH (DEPTH not a power of 2).
- Read, port k, effective value V:
  - 0 if rs_k >= DEPTH, or if ZERO_REG=1 and rs_k == 0.
  - Otherwise, if BYPASS=1, cen=1, we=1, clr=0 and rd_i == rs_k (and the write is not discarded): V = dat_i.
  - Otherwise, if BYPASS=1, cen=1 and clr=1: V = 0.
  - Otherwise V = mem[rs_k].
- READ_LAT=0: rs_o port k = V combinationally, zero latency.
- READ_LAT=1:
  - At a rising edge with cen=1, the port k output register <= V. With cen=0 it holds.
  - Output is valid one cycle after the address is presented.
  - With BYPASS=0 the register captures the pre-write contents.
- Ports are fully independent; any number may read the same address in the same cycle.
- No internal state machine beyond storage. All outputs are free of X after the first reset.
- rst asserted mid-sequence overrides a simultaneous write or clear; the write is lost.

Test Plan (defaults WIDTH=8, DEPTH=8, NUM_RD=2, ZERO_REG=0, BYPASS=1, READ_LAT=0 unless stated):
- Reset then write: rst 1 cycle; read all 8 addresses -> 0x00. Write r3=0xA5, r7=0x3C; read rs0=3, rs1=7 -> 0xA5, 0x3C.
- Bypass and cen:
  - cen=1, we=1, rd_i=5, dat_i=0x99, rs0=5 -> rs_o port 0 = 0x99 in the same cycle. The next cycle, with we=0, it reads 0x99.
  - The same write with cen=0 -> r5 unchanged. BYPASS=0 -> old value shown during the write cycle.
- Clear priority: r1=0x11, r2=0x22; assert clr and we (rd_i=1, dat_i=0xFF) with cen=1 -> all registers 0x00, r1 not written; bypassed read of r1 that cycle = 0x00.
- ZERO_REG=1: write r0=0x55 -> r0 reads 0x00. Simultaneous write r0 with rs0=0 -> 0x00 (no bypass). r4 writes normally.
- READ_LAT=1:
  - Write r6=0x6E; present rs1=6 in cycle N -> 0x6E on rs_o port 1 in cycle N+1.
  - Holding cen=0 freezes the output across an address change.
  - rst clears the output to 0x00.
- Non-power-of-2 (DEPTH=6, AW=3): write rd_i=7, dat_i=0x77 -> ignored, r0..r5 unchanged; read rs0=6 -> 0x00. Also check WIDTH=16 with NUM_RD=3: concurrent reads of three distinct registers return the correct 16-bit values.
